// File: rtl/rtl_settings_pkg.sv
// rtl/rtl_settings_pkg.sv - shared widths, mode enums and compare descriptor for the traffic sequencer
package rtl_settings_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 512;
  localparam int DATA_B_W    = DATA_W / 8;
  localparam int ADDR_B_W    = $clog2(DATA_B_W);
  localparam int CMP_ADDR_W  = ADDR_W - ADDR_B_W;
  localparam int AMM_BURST_W = 8;

  // Address unit of the memory port: "BYTE" or "WORD".
  localparam logic [31:0] ADDR_TYPE    = "BYTE";
  localparam bit          ADDR_IS_BYTE = (ADDR_TYPE == "BYTE");

  typedef enum logic [1:0] {
    READ_ONLY       = 2'd0,
    WRITE_ONLY      = 2'd1,
    WRITE_AND_CHECK = 2'd2
  } test_mode_t;

  typedef enum logic [2:0] {
    FIX_ADDR   = 3'd0,
    RND_ADDR   = 3'd1,
    RUN_0_ADDR = 3'd2,
    RUN_1_ADDR = 3'd3,
    INC_ADDR   = 3'd4
  } addr_mode_t;

  typedef enum logic {
    DATA_FIX  = 1'b0,
    DATA_PRBS = 1'b1
  } data_mode_t;

  typedef struct packed {
    logic [CMP_ADDR_W-1:0]  start_addr;
    logic [ADDR_B_W-1:0]    start_off;
    logic [ADDR_B_W-1:0]    end_off;
    logic                   trans_type;
    logic [AMM_BURST_W-2:0] words_count;
    data_mode_t             data_mode;
    logic [7:0]             data_ptrn;
  } cmp_struct_t;

endpackage

// File: rtl/addr_gen.sv
// rtl/addr_gen.sv - per-transaction address generator (fixed, LFSR, walking bit, incrementing)
// The LFSR survives between runs and is only reseeded by reset.
module addr_gen
  import rtl_settings_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   step_i,
  input  addr_mode_t             mode_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [AMM_BURST_W-2:0] words_i,
  output logic [ADDR_W-1:0]      addr_o
);

  localparam int          K_W       = $clog2(ADDR_W);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  logic [31:0]       lfsr;
  logic [31:0]       lfsr_nxt;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    k_nxt;
  logic [ADDR_W-1:0] words_plus1;
  logic [ADDR_W-1:0] incr;

  function automatic logic [ADDR_W-1:0] one_hot(input logic [K_W-1:0] idx);
    return ADDR_W'(1) << idx;
  endfunction

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  assign lfsr_nxt    = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'h0);
  assign k_nxt       = (k == K_W'(ADDR_W - 1)) ? '0 : k + K_W'(1);
  assign words_plus1 = ADDR_W'(words_i) + ADDR_W'(1);
  assign incr        = ADDR_IS_BYTE ? (words_plus1 << ADDR_B_W) : words_plus1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr   <= LFSR_SEED;
      k      <= '0;
      addr_o <= '0;
    end else if (load_i) begin
      k <= '0;
      case (mode_i)
        RND_ADDR:   addr_o <= ADDR_W'(lfsr);
        RUN_0_ADDR: addr_o <= ~one_hot('0);
        RUN_1_ADDR: addr_o <= one_hot('0);
        default:    addr_o <= base_addr_i;
      endcase
    end else if (step_i) begin
      k <= k_nxt;
      case (mode_i)
        RND_ADDR: begin
          lfsr   <= lfsr_nxt;
          addr_o <= ADDR_W'(lfsr_nxt);
        end
        RUN_0_ADDR: addr_o <= ~one_hot(k_nxt);
        RUN_1_ADDR: addr_o <= one_hot(k_nxt);
        INC_ADDR:   addr_o <= addr_o + incr;
        default:    addr_o <= base_addr_i;
      endcase
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// rtl/test_sequencer.sv - memory traffic sequencer issuing write/read commands and compare descriptors
// Every handshake output is registered; ready inputs only steer the next state.
module test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int          TRANS_CNT_W = 32,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2345
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  test_mode_t             test_mode_i,
  input  addr_mode_t             addr_mode_i,
  input  data_mode_t             data_mode_i,
  input  logic [7:0]             data_ptrn_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [TRANS_CNT_W-1:0] trans_cnt_i,
  input  logic [AMM_BURST_W-2:0] words_i,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic                   cmd_write_o,
  output logic [ADDR_W-1:0]      cmd_addr_o,
  output logic [AMM_BURST_W-2:0] cmd_words_o,
  output logic                   cmp_valid_o,
  input  logic                   cmp_ready_i,
  output cmp_struct_t            cmp_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WR_CMD = 3'd2,
    RD_CMD = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t                 state;
  test_mode_t             test_mode_q;
  addr_mode_t             addr_mode_q;
  data_mode_t             data_mode_q;
  logic [7:0]             data_ptrn_q;
  logic [ADDR_W-1:0]      base_addr_q;
  logic [AMM_BURST_W-2:0] words_q;
  logic [TRANS_CNT_W-1:0] remaining;
  logic [ADDR_W-1:0]      gen_addr;
  logic                   gen_load;
  logic                   gen_step;
  logic                   rd_cmd_done;
  logic                   rd_cmp_done;

  assign gen_load = (state == LOAD);
  assign gen_step = (state == NEXT);

  addr_gen #(
    .LFSR_SEED (LFSR_SEED)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (gen_load),
    .step_i      (gen_step),
    .mode_i      (addr_mode_q),
    .base_addr_i (base_addr_q),
    .words_i     (words_q),
    .addr_o      (gen_addr)
  );

  // In RD_CMD the command and compare channels retire independently.
  assign rd_cmd_done = !cmd_valid_o || cmd_ready_i;
  assign rd_cmp_done = !cmp_valid_o || cmp_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cmd_valid_o <= 1'b0;
      cmd_write_o <= 1'b0;
      cmp_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      test_mode_q <= READ_ONLY;
      addr_mode_q <= FIX_ADDR;
      data_mode_q <= DATA_FIX;
      data_ptrn_q <= '0;
      base_addr_q <= '0;
      words_q     <= '0;
      remaining   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            test_mode_q <= test_mode_i;
            addr_mode_q <= addr_mode_i;
            data_mode_q <= data_mode_i;
            data_ptrn_q <= data_ptrn_i;
            base_addr_q <= base_addr_i;
            words_q     <= words_i;
            remaining   <= trans_cnt_i;
            busy_o      <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (remaining == '0) begin
            done_o <= 1'b1;
            state  <= FINISH;
          end else if (test_mode_q == READ_ONLY) begin
            cmd_valid_o <= 1'b1;
            cmd_write_o <= 1'b0;
            cmp_valid_o <= 1'b1;
            state       <= RD_CMD;
          end else begin
            cmd_valid_o <= 1'b1;
            cmd_write_o <= 1'b1;
            state       <= WR_CMD;
          end
        end
        WR_CMD: begin
          if (cmd_ready_i) begin
            if (test_mode_q == WRITE_AND_CHECK) begin
              cmd_write_o <= 1'b0;
              cmp_valid_o <= 1'b1;
              state       <= RD_CMD;
            end else begin
              cmd_valid_o <= 1'b0;
              state       <= NEXT;
            end
          end
        end
        RD_CMD: begin
          if (cmd_ready_i) cmd_valid_o <= 1'b0;
          if (cmp_ready_i) cmp_valid_o <= 1'b0;
          if (rd_cmd_done && rd_cmp_done) state <= NEXT;
        end
        NEXT: begin
          remaining <= remaining - TRANS_CNT_W'(1);
          if (remaining == TRANS_CNT_W'(1)) begin
            done_o <= 1'b1;
            state  <= FINISH;
          end else if (test_mode_q == READ_ONLY) begin
            cmd_valid_o <= 1'b1;
            cmd_write_o <= 1'b0;
            cmp_valid_o <= 1'b1;
            state       <= RD_CMD;
          end else begin
            cmd_valid_o <= 1'b1;
            cmd_write_o <= 1'b1;
            state       <= WR_CMD;
          end
        end
        FINISH: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_addr_o  = gen_addr;
  assign cmd_words_o = words_q;

  always_comb begin
    cmp_o             = '0;
    cmp_o.start_addr  = gen_addr[ADDR_W-1 -: CMP_ADDR_W];
    cmp_o.start_off   = ADDR_IS_BYTE ? gen_addr[ADDR_B_W-1:0] : '0;
    cmp_o.end_off     = '1;
    cmp_o.trans_type  = 1'b0;
    cmp_o.words_count = words_q;
    cmp_o.data_mode   = data_mode_q;
    cmp_o.data_ptrn   = data_ptrn_q;
  end

endmodule

// File: tb/tb_test_sequencer.sv
// tb/tb_test_sequencer.sv - self-checking bench for test_sequencer
module tb_test_sequencer;
  import rtl_settings_pkg::*;

  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b0;
  logic                   start_i = 1'b0;
  test_mode_t             test_mode_i = READ_ONLY;
  addr_mode_t             addr_mode_i = FIX_ADDR;
  data_mode_t             data_mode_i = DATA_FIX;
  logic [7:0]             data_ptrn_i = '0;
  logic [ADDR_W-1:0]      base_addr_i = '0;
  logic [31:0]            trans_cnt_i = '0;
  logic [AMM_BURST_W-2:0] words_i = '0;
  logic                   cmd_valid_o;
  logic                   cmd_ready_i = 1'b0;
  logic                   cmd_write_o;
  logic [ADDR_W-1:0]      cmd_addr_o;
  logic [AMM_BURST_W-2:0] cmd_words_o;
  logic                   cmp_valid_o;
  logic                   cmp_ready_i = 1'b0;
  cmp_struct_t            cmp_o;
  logic                   busy_o;
  logic                   done_o;

  test_sequencer #(.TRANS_CNT_W(32), .LFSR_SEED(SEED)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .test_mode_i(test_mode_i), .addr_mode_i(addr_mode_i), .data_mode_i(data_mode_i),
    .data_ptrn_i(data_ptrn_i), .base_addr_i(base_addr_i), .trans_cnt_i(trans_cnt_i),
    .words_i(words_i), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_write_o(cmd_write_o), .cmd_addr_o(cmd_addr_o), .cmd_words_o(cmd_words_o),
    .cmp_valid_o(cmp_valid_o), .cmp_ready_i(cmp_ready_i), .cmp_o(cmp_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic                   w;
    logic [ADDR_W-1:0]      a;
    logic [AMM_BURST_W-2:0] n;
  } cmd_t;

  typedef struct {
    test_mode_t  tm;
    addr_mode_t  am;
    logic [31:0] base;
    int          cnt;
    logic [6:0]  w;
    int          n_cmd;
    int          n_cmp;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  cmd_t        cmd_q[$];
  cmd_t        exp_cmd[$];
  cmp_struct_t cmp_q[$];
  cmp_struct_t exp_cmp[$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [31:0] m_lfsr = SEED;

  bit          ready_mode = 1'b0;
  logic        force_cmd = 1'b1;
  logic        force_cmp = 1'b1;
  logic [5:0]  hist = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Ready driver: the compare ready replays the command ready five cycles late.
  always @(posedge clk_i) begin
    #1;
    hist = {hist[4:0], ($urandom_range(0, 2) != 0)};
    if (ready_mode) begin
      cmd_ready_i = hist[0];
      cmp_ready_i = hist[5];
    end else begin
      cmd_ready_i = force_cmd;
      cmp_ready_i = force_cmp;
    end
  end

  cmd_t        cmd_hold;
  cmp_struct_t cmp_hold;
  logic        cmd_pend = 1'b0;
  logic        cmp_pend = 1'b0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      cmd_pend = 1'b0;
      cmp_pend = 1'b0;
    end else begin
      if (cmd_pend)
        chk("cmd_stable", 64'({cmd_valid_o, cmd_write_o, cmd_addr_o, cmd_words_o}), 64'({1'b1, cmd_hold}));
      if (cmp_pend)
        chk("cmp_stable", 64'({cmp_valid_o, cmp_o}), 64'({1'b1, cmp_hold}));
      cmd_pend = 1'b0;
      cmp_pend = 1'b0;
      if (cmd_valid_o) begin
        cmd_hold = {cmd_write_o, cmd_addr_o, cmd_words_o};
        if (cmd_ready_i) cmd_q.push_back(cmd_hold);
        else cmd_pend = 1'b1;
      end
      if (cmp_valid_o) begin
        cmp_hold = cmp_o;
        if (cmp_ready_i) cmp_q.push_back(cmp_hold);
        else cmp_pend = 1'b1;
      end
      if (done_o) done_cnt++;
    end
  end

  // Reference: list of transactions implied by the configuration.
  task automatic build_exp(input test_mode_t tm, input addr_mode_t am, input data_mode_t dm,
                           input logic [7:0] pt, input logic [31:0] base, input int cnt, input logic [6:0] w);
    logic [31:0] a;
    cmp_struct_t c;
    exp_cmd.delete();
    exp_cmp.delete();
    for (int i = 0; i < cnt; i++) begin
      case (am)
        FIX_ADDR:   a = base;
        RND_ADDR: begin
          a = m_lfsr;
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
        RUN_0_ADDR: a = ~(32'h1 << (i % ADDR_W));
        RUN_1_ADDR: a = 32'h1 << (i % ADDR_W);
        default:    a = base + 32'(i * (int'(w) + 1) * DATA_B_W);
      endcase
      if (tm != READ_ONLY) exp_cmd.push_back({1'b1, a, w});
      if (tm != WRITE_ONLY) begin
        exp_cmd.push_back({1'b0, a, w});
        c.start_addr  = a[ADDR_W-1:ADDR_B_W];
        c.start_off   = a[ADDR_B_W-1:0];
        c.end_off     = '1;
        c.trans_type  = 1'b0;
        c.words_count = w;
        c.data_mode   = dm;
        c.data_ptrn   = pt;
        exp_cmp.push_back(c);
      end
    end
  endtask

  task automatic run_test(input string tag, input test_mode_t tm, input addr_mode_t am, input data_mode_t dm,
                          input logic [7:0] pt, input logic [31:0] base, input int cnt, input logic [6:0] w,
                          input bit poke);
    int t;
    build_exp(tm, am, dm, pt, base, cnt, w);
    cmd_q.delete();
    cmp_q.delete();
    done_cnt = 0;
    test_mode_i = tm; addr_mode_i = am; data_mode_i = dm; data_ptrn_i = pt;
    base_addr_i = base; trans_cnt_i = 32'(cnt); words_i = w; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    test_mode_i = test_mode_t'($urandom_range(0, 2));
    addr_mode_i = addr_mode_t'($urandom_range(0, 4));
    base_addr_i = $urandom;
    words_i     = 7'($urandom);
    data_ptrn_i = 8'($urandom);
    trans_cnt_i = 32'($urandom_range(1, 9));
    if (poke) begin
      tick();
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 20000) begin
      tick();
      t++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) tick();
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    chk({tag, "_n_cmd"}, 64'(cmd_q.size()), 64'(exp_cmd.size()));
    chk({tag, "_n_cmp"}, 64'(cmp_q.size()), 64'(exp_cmp.size()));
    for (int i = 0; i < exp_cmd.size() && i < cmd_q.size(); i++)
      chk({tag, "_cmd"}, 64'(cmd_q[i]), 64'(exp_cmd[i]));
    for (int i = 0; i < exp_cmp.size() && i < cmp_q.size(); i++)
      chk({tag, "_cmp"}, 64'(cmp_q[i]), 64'(exp_cmp[i]));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{WRITE_AND_CHECK, FIX_ADDR,   32'h0000_1000, 3,  7'd0,   6,  3, 32'h0000_1000, 32'h0000_1000};
    vecs[1] = '{READ_ONLY,       INC_ADDR,   32'h0000_0000, 4,  7'd1,   4,  4, 32'h0000_0000, 32'h0000_0180};
    vecs[2] = '{WRITE_ONLY,      RUN_1_ADDR, 32'h0000_0000, 33, 7'd0,   33, 0, 32'h0000_0001, 32'h0000_0001};
    vecs[3] = '{WRITE_ONLY,      RUN_0_ADDR, 32'h1234_5678, 2,  7'd5,   2,  0, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[4] = '{READ_ONLY,       INC_ADDR,   32'hFFFF_FFC0, 2,  7'd0,   2,  2, 32'hFFFF_FFC0, 32'h0000_0000};
    vecs[5] = '{WRITE_AND_CHECK, FIX_ADDR,   32'hABCD_EF40, 1,  7'd127, 2,  1, 32'hABCD_EF40, 32'hABCD_EF40};

    repeat (3) tick();
    chk("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    chk("rst_cmp_valid", 64'(cmp_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_addr", 64'(cmd_addr_o), 64'd0);
    rst_i = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_test($sformatf("vec%0d", v), vecs[v].tm, vecs[v].am, DATA_FIX, 8'hC3,
               vecs[v].base, vecs[v].cnt, vecs[v].w, 1'b0);
      chk($sformatf("vec%0d_tab_n_cmd", v), 64'(cmd_q.size()), 64'(vecs[v].n_cmd));
      chk($sformatf("vec%0d_tab_n_cmp", v), 64'(cmp_q.size()), 64'(vecs[v].n_cmp));
      if (cmd_q.size() > 0) begin
        chk($sformatf("vec%0d_tab_first", v), 64'(cmd_q[0].a), 64'(vecs[v].first));
        chk($sformatf("vec%0d_tab_last", v), 64'(cmd_q[cmd_q.size()-1].a), 64'(vecs[v].last));
      end
    end

    // Zero-length run: done two cycles after start, no traffic.
    cmd_q.delete();
    cmp_q.delete();
    trans_cnt_i = '0;
    test_mode_i = WRITE_AND_CHECK;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("cnt0_busy_load", 64'(busy_o), 64'd1);
    chk("cnt0_done_early", 64'(done_o), 64'd0);
    tick();
    chk("cnt0_done", 64'(done_o), 64'd1);
    tick();
    chk("cnt0_done_drop", 64'(done_o), 64'd0);
    chk("cnt0_busy_drop", 64'(busy_o), 64'd0);
    chk("cnt0_no_valid", 64'(cmd_q.size() + cmp_q.size()), 64'd0);

    // A start pulse during a run must be ignored.
    run_test("poke", WRITE_AND_CHECK, INC_ADDR, DATA_PRBS, 8'h5A, 32'h0000_4000, 4, 7'd3, 1'b1);

    ready_mode = 1'b1;
    for (int n = 0; n < 25; n++) begin
      run_test($sformatf("rnd%0d", n), test_mode_t'($urandom_range(0, 2)), addr_mode_t'($urandom_range(0, 4)),
               data_mode_t'($urandom_range(0, 1)), 8'($urandom), $urandom, int'($urandom_range(1, 6)),
               7'($urandom), 1'b0);
    end

    // Reset while a write command is stalled, then a fresh random-address run.
    ready_mode = 1'b0;
    force_cmd = 1'b0;
    force_cmp = 1'b0;
    tick();
    test_mode_i = WRITE_ONLY;
    addr_mode_i = FIX_ADDR;
    base_addr_i = 32'h2222_0000;
    trans_cnt_i = 32'd2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("rst_mid_pre_valid", 64'(cmd_valid_o), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mid_cmd_valid", 64'(cmd_valid_o), 64'd0);
    chk("rst_mid_cmp_valid", 64'(cmp_valid_o), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_done", 64'(done_o), 64'd0);
    tick();
    tick();
    rst_i = 1'b1;
    m_lfsr = SEED;
    force_cmd = 1'b1;
    force_cmp = 1'b1;
    tick();
    tick();
    run_test("fresh", WRITE_AND_CHECK, RND_ADDR, DATA_PRBS, 8'h3C, 32'h0, 3, 7'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter TRANS_CNT_W, default 32, width of the transaction count.
REQ-002 Parameter LFSR_SEED, default 32'hACE1_2345, random-address seed; SHALL be nonzero.
REQ-003 clk_i  input  1  single clock.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  one-cycle start pulse.
REQ-006 test_mode_i  input  test_mode_t  READ_ONLY / WRITE_ONLY / WRITE_AND_CHECK.
REQ-007 addr_mode_i  input  addr_mode_t  FIX / RND / RUN_0 / RUN_1 / INC.
REQ-008 data_mode_i  input  data_mode_t; data_ptrn_i  input  8  fixed pattern or PRBS seed.
REQ-009 base_addr_i  input  ADDR_W  fixed or start address.
REQ-010 trans_cnt_i  input  TRANS_CNT_W  number of transactions.
REQ-011 words_i  input  AMM_BURST_W-1  burst length minus one.
REQ-012 cmd_valid_o  output  1; cmd_ready_i  input  1; cmd_write_o  output  1  (1 = write); cmd_addr_o  output  ADDR_W; cmd_words_o  output  AMM_BURST_W-1.
REQ-013 cmp_valid_o  output  1; cmp_ready_i  input  1; cmp_o  output  cmp_struct_t.
REQ-014 busy_o  output  1; done_o  output  1  one-cycle completion pulse.

Function
REQ-015 States: IDLE, LOAD, WR_CMD, RD_CMD, NEXT, FINISH.
REQ-016 IDLE: start_i=1 latches all *_i configuration, goes to LOAD; start_i while not IDLE is ignored.
REQ-017 LOAD: trans_cnt=0 -> FINISH; otherwise computes the first address, then WR_CMD (WRITE_ONLY, WRITE_AND_CHECK) or RD_CMD (READ_ONLY).
REQ-018 WR_CMD: cmd_valid_o=1, cmd_write_o=1; on cmd_ready_i -> RD_CMD if WRITE_AND_CHECK, else NEXT.
REQ-019 RD_CMD: cmd_valid_o=1, cmd_write_o=0 and cmp_valid_o=1 together; each is accepted independently, dropped after its own handshake; exit to NEXT once both are accepted (same or different cycles).
REQ-020 Valid/ready: once valid is asserted, payload is held stable and valid stays high until ready; no combinational path ready -> valid.
REQ-021 NEXT: decrement remaining count; zero -> FINISH, else advance address -> WR_CMD/RD_CMD per REQ-017.
REQ-022 FINISH: done_o=1 for exactly one cycle, then IDLE; busy_o=1 in every state except IDLE.
REQ-023 FIX_ADDR: every transaction uses base_addr.
REQ-024 RND_ADDR: 32-bit Galois LFSR, taps 32,22,2,1, seeded at reset, stepped once per NEXT; address = low ADDR_W bits.
REQ-025 RUN_0_ADDR: all ones except bit k; RUN_1_ADDR: only bit k set; k starts at 0, +1 per transaction, wraps ADDR_W-1 -> 0.
REQ-026 INC_ADDR: addr += (words+1)*DATA_B_W when ADDR_TYPE="BYTE", else +(words+1); modulo 2^ADDR_W, wraps silently.
REQ-027 cmp_o: start_addr = addr upper CMP_ADDR_W bits; start_off = addr low ADDR_B_W bits ("BYTE"), else 0; end_off = all ones; trans_type=0; words_count=words; data_mode and data_ptrn as latched.
REQ-028 cmd_words_o = latched words; cmd_addr_o = current address.

Reset
REQ-029 rst_i low: state IDLE, cmd_valid_o=0, cmp_valid_o=0, busy_o=0, done_o=0, counters 0, LFSR=LFSR_SEED, k=0; asynchronous, including mid-transaction (pending command discarded).

Structure
REQ-030 test_mode_t, addr_mode_t, data_mode_t, cmp_struct_t, ADDR_W, CMP_ADDR_W, ADDR_B_W, DATA_B_W live in rtl_settings_pkg; state enum is local.
REQ-031 Address generation in one sub-module addr_gen (load, step, mode -> addr).

Verification
REQ-032 WRITE_AND_CHECK, FIX, base=0x1000, cnt=3, ready=1 -> W,R,W,R,W,R at 0x1000, 3 cmp, done_o one pulse.
REQ-033 READ_ONLY, INC, BYTE, DATA_B_W=64, words=1, base=0, cnt=4 -> read addrs 0x0,0x80,0x100,0x180; no writes.
REQ-034 RUN_1, cnt=ADDR_W+1 -> addrs 1,2,4,...,2^(ADDR_W-1),1.
REQ-035 Random ready stalls, cmp_ready 5 cycles later than cmd_ready -> payload stable, no duplicate or lost handshakes, single exit per transaction.
REQ-036 cnt=0 -> done_o 2 cycles after start, no valids; rst_i low mid-WR_CMD -> all outputs 0 immediately, next start behaves as fresh.
